// File: rtl/branch_predictor_if.sv
// Branch-unit <-> predictor bus.
//   master : branch unit; drives query_* and commit_*, receives the prediction
//            bundle and the perf counters.
//   slave  : predictor; receives query_* and commit_*, drives prediction,
//            pattern, addr_on_failure, n_branch and n_failure.
interface branch_predictor_if #(
  parameter int unsigned PATTERN_WIDTH  = 4,
  parameter int unsigned INST_MEM_WIDTH = 14
);

  // Issue-side query
  logic                      query_valid;
  logic [INST_MEM_WIDTH-1:0] query_pc;
  logic [INST_MEM_WIDTH-1:0] query_target;

  // Prediction bundle (combinational from predictor state and query_*)
  logic                      prediction;
  logic [PATTERN_WIDTH-1:0]  pattern;
  logic [INST_MEM_WIDTH-1:0] addr_on_failure;

  // Commit-side training / repair
  logic                      commit_valid;
  logic [PATTERN_WIDTH-1:0]  commit_pattern;
  logic                      commit_taken;
  logic                      commit_failure;

  // Perf counters
  logic [31:0]               n_branch;
  logic [31:0]               n_failure;

  modport master (
    output query_valid, query_pc, query_target,
    output commit_valid, commit_pattern, commit_taken, commit_failure,
    input  prediction, pattern, addr_on_failure,
    input  n_branch, n_failure
  );

  modport slave (
    input  query_valid, query_pc, query_target,
    input  commit_valid, commit_pattern, commit_taken, commit_failure,
    output prediction, pattern, addr_on_failure,
    output n_branch, n_failure
  );

endinterface

// File: rtl/branch_predictor.sv
// GAg conditional-branch predictor.
// A single speculative global history register directly indexes a table of
// 2-bit saturating counters. Queries are answered combinationally from the
// registered state; commits train the table and, on a mispredict, rebuild the
// history from the pattern stored with the failing branch.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high; restores history, table and counters
//   bp    : slave side of branch_predictor_if (query, prediction, commit,
//           perf counters)
module branch_predictor #(
  parameter int unsigned PATTERN_WIDTH  = 4,
  parameter int unsigned INST_MEM_WIDTH = 14
) (
  input  logic               clk,
  input  logic               reset,
  branch_predictor_if.slave  bp
);

  localparam int unsigned W         = PATTERN_WIDTH;
  localparam int unsigned AW        = INST_MEM_WIDTH;
  localparam int unsigned PHT_DEPTH = 2 ** PATTERN_WIDTH;
  localparam logic [1:0]  CNT_INIT  = 2'b01;
  localparam logic [1:0]  CNT_MAX   = 2'b11;
  localparam logic [1:0]  CNT_MIN   = 2'b00;

  logic [W-1:0]  ghr_q, ghr_d;
  logic [1:0]    pht_q [PHT_DEPTH];
  logic [1:0]    pht_d [PHT_DEPTH];
  logic [31:0]   n_branch_q, n_branch_d;
  logic [31:0]   n_failure_q, n_failure_d;

  logic          pred;
  logic [1:0]    cnt_cur;
  logic [1:0]    cnt_nxt;
  logic          repair;

  // Query path: prediction from the pre-update counter at the current history
  always_comb begin
    pred               = pht_q[ghr_q][1];
    bp.prediction      = pred;
    bp.pattern         = ghr_q;
    bp.addr_on_failure = pred ? (bp.query_pc + AW'(1)) : bp.query_target;
  end

  // Saturating counter step for the committing branch's table entry
  always_comb begin
    cnt_cur = pht_q[bp.commit_pattern];
    cnt_nxt = cnt_cur;
    if (bp.commit_taken) begin
      if (cnt_cur != CNT_MAX) cnt_nxt = cnt_cur + 2'(1);
    end else begin
      if (cnt_cur != CNT_MIN) cnt_nxt = cnt_cur - 2'(1);
    end
  end

  assign repair = bp.commit_valid && bp.commit_failure;

  // Next-state: training, perf counters and history (repair beats a
  // same-cycle query, which belongs to the flushed path)
  always_comb begin
    pht_d       = pht_q;
    n_branch_d  = n_branch_q;
    n_failure_d = n_failure_q;
    ghr_d       = ghr_q;

    if (bp.commit_valid) begin
      pht_d[bp.commit_pattern] = cnt_nxt;
      n_branch_d               = n_branch_q + 32'(1);
      n_failure_d              = n_failure_q + 32'(bp.commit_failure);
    end

    if (repair) begin
      ghr_d = {bp.commit_pattern[W-2:0], bp.commit_taken};
    end else if (bp.query_valid) begin
      ghr_d = {ghr_q[W-2:0], pred};
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q       <= '0;
      n_branch_q  <= '0;
      n_failure_q <= '0;
      for (int i = 0; i < PHT_DEPTH; i++) begin
        pht_q[i] <= CNT_INIT;
      end
    end else begin
      ghr_q       <= ghr_d;
      n_branch_q  <= n_branch_d;
      n_failure_q <= n_failure_d;
      for (int i = 0; i < PHT_DEPTH; i++) begin
        pht_q[i] <= pht_d[i];
      end
    end
  end

  assign bp.n_branch  = n_branch_q;
  assign bp.n_failure = n_failure_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by a
// randomized stream, all compared against an arithmetic reference model.
module tb_branch_predictor;

  localparam int unsigned PW  = 4;
  localparam int unsigned AW  = 14;
  localparam int          NPHT = 16;

  logic clk;
  logic reset;

  branch_predictor_if #(.PATTERN_WIDTH(PW), .INST_MEM_WIDTH(AW)) bus ();

  branch_predictor #(.PATTERN_WIDTH(PW), .INST_MEM_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int          m_pht [NPHT];
  int          m_ghr;
  int unsigned m_nb;
  int unsigned m_nf;

  int errors;
  int checks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NPHT; i++) m_pht[i] = 1;
    m_ghr = 0;
    m_nb  = 0;
    m_nf  = 0;
  endtask

  function automatic int model_pred();
    return (m_pht[m_ghr] >= 2) ? 1 : 0;
  endfunction

  // One clock cycle: drive, compare outputs against the model, advance both
  task automatic step(input logic rst, input logic qv, input int pc, input int tgt,
                      input logic cv, input int cp, input logic ct, input logic cf);
    int p;
    int exp_addr;
    reset              = rst;
    bus.query_valid    = qv;
    bus.query_pc       = AW'(pc);
    bus.query_target   = AW'(tgt);
    bus.commit_valid   = cv;
    bus.commit_pattern = PW'(cp);
    bus.commit_taken   = ct;
    bus.commit_failure = cf;
    #2;
    p        = model_pred();
    exp_addr = (p == 1) ? ((pc + 1) % (1 << AW)) : tgt;
    check("prediction", 32'(bus.prediction), 32'(p));
    check("pattern", 32'(bus.pattern), 32'(m_ghr));
    check("addr_on_failure", 32'(bus.addr_on_failure), 32'(exp_addr));
    check("n_branch", bus.n_branch, m_nb);
    check("n_failure", bus.n_failure, m_nf);

    if (rst) begin
      model_reset();
    end else begin
      if (cv) begin
        if (ct) m_pht[cp] = (m_pht[cp] < 3) ? m_pht[cp] + 1 : 3;
        else    m_pht[cp] = (m_pht[cp] > 0) ? m_pht[cp] - 1 : 0;
        m_nb = m_nb + 1;
        if (cf) m_nf = m_nf + 1;
      end
      if (cv && cf)  m_ghr = ((cp * 2) + int'(ct)) % NPHT;
      else if (qv)   m_ghr = ((m_ghr * 2) + p) % NPHT;
    end
    @(posedge clk);
    #1;
  endtask

  // Literal expectations on state-derived outputs between steps
  task automatic expect_state(input string tag, input int pred, input int pat,
                              input int nb, input int nf);
    check({tag, ".prediction"}, 32'(bus.prediction), 32'(pred));
    check({tag, ".pattern"}, 32'(bus.pattern), 32'(pat));
    check({tag, ".n_branch"}, bus.n_branch, 32'(nb));
    check({tag, ".n_failure"}, bus.n_failure, 32'(nf));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.query_valid = 1'b0; bus.query_pc = '0; bus.query_target = '0;
    bus.commit_valid = 1'b0; bus.commit_pattern = '0;
    bus.commit_taken = 1'b0; bus.commit_failure = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state and first query
    step(1'b0, 1'b1, 16'h0010, 16'h0100, 1'b0, 0, 1'b0, 1'b0);
    expect_state("after_first_query", 0, 0, 0, 0);

    // Train pht[0] to strongly taken, then query at ghr=0
    repeat (3) step(1'b0, 1'b0, 0, 0, 1'b1, 0, 1'b1, 1'b0);
    expect_state("pht0_trained", 1, 0, 3, 0);
    step(1'b0, 1'b1, 16'h0020, 16'h0200, 1'b0, 0, 1'b0, 1'b0);
    expect_state("after_taken_query", 0, 1, 3, 0);

    // Repair to 0x5, then failing commit racing a query -> 0x7
    step(1'b0, 1'b0, 0, 0, 1'b1, 2, 1'b1, 1'b1);
    expect_state("repair_to_5", 0, 5, 4, 1);
    step(1'b0, 1'b1, 16'h0040, 16'h0400, 1'b1, 3, 1'b1, 1'b1);
    expect_state("repair_beats_query", 0, 7, 5, 2);

    // Reset with concurrent query and commit wipes trained state
    step(1'b1, 1'b1, 16'h0050, 16'h0500, 1'b1, 0, 1'b1, 1'b1);
    expect_state("reset_midstream", 0, 0, 0, 0);

    // Same-cycle query and non-failing commit to index 0x2
    step(1'b0, 1'b0, 0, 0, 1'b1, 1, 1'b0, 1'b1);
    expect_state("ghr_set_2", 0, 2, 1, 1);
    step(1'b0, 1'b1, 16'h0060, 16'h0600, 1'b1, 2, 1'b1, 1'b0);
    expect_state("query_used_old_pht", 0, 4, 2, 1);
    step(1'b0, 1'b0, 0, 0, 1'b1, 1, 1'b0, 1'b1);
    expect_state("pht2_visible", 1, 2, 3, 2);

    // Saturation at 0 for index 0xF
    step(1'b0, 1'b0, 0, 0, 1'b1, 7, 1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b0, 0, 0, 1'b1, 15, 1'b0, 1'b0);
    expect_state("pht15_floor", 0, 15, 9, 3);
    step(1'b0, 1'b0, 0, 0, 1'b1, 15, 1'b1, 1'b0);
    expect_state("pht15_one_up", 0, 15, 10, 3);
    step(1'b0, 1'b0, 0, 0, 1'b1, 15, 1'b1, 1'b0);
    expect_state("pht15_two_up", 1, 15, 11, 3);

    // PC wrap on a taken prediction
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 0, 0, 1'b1, 0, 1'b1, 1'b0);
    bus.query_pc     = 14'h3FFF;
    bus.query_target = 14'h1234;
    #1;
    check("pc_wrap_addr", 32'(bus.addr_on_failure), 32'h0);
    step(1'b0, 1'b1, 16'h3FFF, 16'h1234, 1'b0, 0, 1'b0, 1'b0);

    // Randomized stream
    for (int n = 0; n < 400; n++) begin
      logic r_rst, r_qv, r_cv, r_ct, r_cf;
      r_rst = ($urandom_range(0, 99) == 0);
      r_qv  = 1'($urandom);
      r_cv  = ($urandom_range(0, 2) != 0);
      r_ct  = ($urandom_range(0, 3) != 0);
      r_cf  = ($urandom_range(0, 4) == 0);
      step(r_rst, r_qv, int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)),
           r_cv, int'($urandom_range(0, NPHT - 1)), r_ct, r_cf);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Global-history (GAg) conditional-branch predictor feeding the branch unit. For each conditional branch leaving issue, it supplies three things:
- a taken/not-taken prediction;
- the history pattern used to make it;
- the address to redirect to if the prediction later fails.

At commit it trains its 2-bit counters from the resolved outcome and, on failure, repairs its speculative history so fetch after the flush sees correct history.

## Interface
- PATTERN_WIDTH, 4, global history length; the PHT has 2**PATTERN_WIDTH entries indexed directly by history
- INST_MEM_WIDTH, 14, instruction address width
- clk  in  1  clock; everything is synchronous to its rising edge
- reset  in  1  synchronous, active-high reset
- query_valid  in  1  a conditional branch is issued to the branch unit this cycle (issue handshake completed)
- query_pc  in  INST_MEM_WIDTH  address of that branch
- query_target  in  INST_MEM_WIDTH  taken target of that branch
- prediction  out  1  predicted direction (1 = taken), combinational
- pattern  out  PATTERN_WIDTH  history used for this prediction, combinational
- addr_on_failure  out  INST_MEM_WIDTH  fetch address if the prediction fails, combinational
- commit_valid  in  1  the oldest branch commits this cycle
- commit_pattern  in  PATTERN_WIDTH  pattern stored with that branch
- commit_taken  in  1  resolved direction of that branch
- commit_failure  in  1  that branch was mispredicted; the pipeline flushes this cycle
- n_branch  out  32  committed-branch count
- n_failure  out  32  committed-failure count

## Operation
State:
- ghr: speculative history, PATTERN_WIDTH bits.
- pht: 2**PATTERN_WIDTH entries of 2-bit saturating counters.
- n_branch and n_failure perf counters.

Query (combinational):
- pattern = ghr.
- prediction = pht[ghr][1].
- addr_on_failure = prediction ? query_pc+1 : query_target. The +1 is modulo 2**INST_MEM_WIDTH, so 0x3FFF+1 = 0x0000.
- Outputs are driven whether or not query_valid is high. The branch unit latches them only on issue.

Speculative update, on query_valid with no failure in the same cycle:
- ghr <= {ghr[W-2:0], prediction}, where W = PATTERN_WIDTH.

Commit update, on commit_valid:
- pht[commit_pattern] increments if commit_taken, decrements otherwise.
- The counter saturates at 3 and at 0.
- n_branch += 1; n_failure += commit_failure. Both counters wrap modulo 2**32.

Repair, on commit_valid && commit_failure:
- ghr <= {commit_pattern[W-2:0], commit_taken}.
- This takes priority over a same-cycle query. That query belongs to the flushed path and has no effect on ghr or pht.

Read/write ordering:
- A query reads the pre-update PHT value even when the commit writes the same index in the same cycle.
- The written value is visible to queries from the next cycle on.

Reset:
- ghr = 0.
- Every pht entry = 2'b01 (weakly not-taken).
- n_branch = n_failure = 0.
- Resulting output values: prediction = 0, pattern = 0, addr_on_failure = query_target.
- Reset overrides any concurrent query or commit. A reset mid-stream discards all history and training.

commit_failure and commit_taken are ignored when commit_valid = 0.

## Timing
- prediction, pattern and addr_on_failure: zero-latency combinational from query_pc, query_target and registered state. There is no path from commit_* to these outputs in the same cycle.
- ghr, pht and the counters update at the edge ending the query/commit cycle.
- Back-to-back queries:
  - each query sees the ghr produced by the previous one, i.e. one history bit per cycle;
  - at most one query per cycle.
- At most one commit per cycle.
- A query and a non-failing commit in the same cycle both take effect, the query using the pre-commit PHT.
- A query and a failing commit in the same cycle: only the commit takes effect.
- The first query after a repair (the cycle after the failure) predicts from the repaired ghr.
- There are no internal stalls and no ready signal: the block accepts a query and a commit every cycle.

## Test plan
- Reset, then query with query_pc=0x0010, query_target=0x0100 -> prediction=0, pattern=0x0, addr_on_failure=0x0100; next cycle ghr=0x0.
- Three commits with commit_pattern=0x0, commit_taken=1 -> pht[0] walks 1→2→3→3. A query at ghr=0 then gives prediction=1 and addr_on_failure=query_pc+1; ghr becomes 0x1.
- ghr=0x5 at a failing commit (commit_pattern=0x3, commit_taken=1, commit_failure=1) with a concurrent query -> next cycle ghr=0x7; n_failure and n_branch each +1; the concurrent query has no effect on ghr.
- Same-cycle query and non-failing commit to index 0x2, with pht[0x2]=1 and commit_taken=1 -> prediction that cycle = 0; the following query at ghr=0x2 gives prediction = 1.
- Saturation and wrap:
  - five not-taken commits at index 0xF -> counter stays 0;
  - query_pc=0x3FFF, predicted taken -> addr_on_failure=0x0000.
- Reset asserted while query_valid and commit_valid are both 1, with trained state -> ghr=0, all pht entries=1, n_branch=n_failure=0 on the next cycle.
